cp0_exc_ctrl: RTL and testbench

//  Sequencer and arbiter for the single CP0 register port. Muxes pipeline MTC0/MFC0 with exception entry and ERET.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/exc_prio_enc.sv | 31 +++
 rtl/cp0_exc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, exception codes, sequencer states.
// Imported by cp0_exc_ctrl and exc_prio_enc.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_SR,
    S_W_BADV,
    S_REDIR,
    S_E_SR,
    S_E_REDIR
  } state_t;

  function automatic logic is_addr_exc(
    input logic [4:0] code
  );
    return (code == EXC_ADEL) ||
           (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder:
// flags + masked interrupt -> {valid, ExcCode}.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       i_adel,
  input  logic       i_ri,
  input  logic       i_ov,
  input  logic       i_sys,
  input  logic       i_ades,
  input  logic       i_int,
  output logic       o_valid,
  output logic [4:0] o_code
);

  // Highest-priority active source wins.
  always_comb begin
    o_valid = 1'b1;
    o_code  = EXC_INT;
    priority case (1'b1)
      i_adel:  o_code = EXC_ADEL;
      i_ri:    o_code = EXC_RI;
      i_ov:    o_code = EXC_OV;
      i_sys:   o_code = EXC_SYS;
      i_ades:  o_code = EXC_ADES;
      i_int:   o_code = EXC_INT;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 port sequencer: MTC0/MFC0 pass-through, exception entry, ERET.
// Optional BadVAddr write step enabled by macro CP0_BADVADDR_EN.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          SR_EXL_BIT = 1,
  parameter int          SR_IE_BIT  = 0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [5:0]  IntReq,
  input  logic        ExcAdEL,
  input  logic        ExcRI,
  input  logic        ExcOv,
  input  logic        ExcSys,
  input  logic        ExcAdES,
  input  logic [31:0] ExcPC,
  input  logic [31:0] ExcBadAddr,
  input  logic        EretReq,
  input  logic        MtcReq,
  input  logic [4:0]  MtcIdx,
  input  logic [31:0] MtcData,
  input  logic [4:0]  MfcIdx,
  input  logic [31:0] CP0Rdata,
  input  logic [31:0] CP0Epc,
  output logic [4:0]  CP0Idx,
  output logic [31:0] CP0Din,
  output logic        CP0Wr,
  output logic        CP0Exc,
  output logic [4:0]  CP0Cause,
  output logic [31:0] MfcData,
  output logic        Busy,
  output logic        PcLoad,
  output logic [31:0] NewPC
);

  localparam logic [31:0] EXL_MASK = 32'd1 << SR_EXL_BIT;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic [31:0] r_sr;
`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badv;
`else
  logic        w_unused_badv;
  assign w_unused_badv = ^ExcBadAddr;
`endif

  logic        w_int;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_idle;
  logic        w_take;
  logic        w_unused_sr;

  logic [4:0]  w_idx;
  logic [31:0] w_din;
  logic        w_wr;
  logic        w_cexc;
  logic [4:0]  w_cause;
  logic        w_pcload;
  logic [31:0] w_newpc;

  assign w_int = (|(IntReq & r_sr[15:10])) &
                 r_sr[SR_IE_BIT] &
                 ~r_sr[SR_EXL_BIT];
  assign w_unused_sr = ^r_sr;

  exc_prio_enc u_prio (
    .i_adel  (ExcAdEL),
    .i_ri    (ExcRI),
    .i_ov    (ExcOv),
    .i_sys   (ExcSys),
    .i_ades  (ExcAdES),
    .i_int   (w_int),
    .o_valid (w_exc),
    .o_code  (w_code)
  );

  assign w_idle = (r_state == S_IDLE);
  assign w_take = w_idle & w_exc;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Capture cause/PC on entry; track SR writes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_code <= '0;
      r_pc   <= '0;
      r_sr   <= '0;
`ifdef CP0_BADVADDR_EN
      r_badv <= '0;
`endif
    end else begin
      if (w_take) begin
        r_code <= w_code;
        r_pc   <= ExcPC;
`ifdef CP0_BADVADDR_EN
        r_badv <= ExcBadAddr;
`endif
      end
      if (w_wr && (w_idx == CP0_SR))
        r_sr <= w_din;
    end
  end

  // Next state and port decode.
  always_comb begin
    w_next   = r_state;
    w_idx    = '0;
    w_din    = '0;
    w_wr     = 1'b0;
    w_cexc   = 1'b0;
    w_cause  = '0;
    w_pcload = 1'b0;
    w_newpc  = '0;
    unique case (r_state)
      S_IDLE: begin
        w_idx = MtcReq ? MtcIdx : MfcIdx;
        w_din = MtcData;
        w_wr  = MtcReq & ~w_exc;
        if (w_exc)        w_next = S_W_EPC;
        else if (EretReq) w_next = S_E_SR;
      end
      S_W_EPC: begin
        w_idx   = CP0_EPC;
        w_din   = r_pc;
        w_wr    = 1'b1;
        w_cexc  = 1'b1;
        w_cause = r_code;
        w_next  = S_W_SR;
      end
      S_W_SR: begin
        w_idx  = CP0_SR;
        w_din  = CP0Rdata | EXL_MASK;
        w_wr   = 1'b1;
`ifdef CP0_BADVADDR_EN
        w_next = is_addr_exc(r_code) ?
                 S_W_BADV : S_REDIR;
`else
        w_next = S_REDIR;
`endif
      end
      S_W_BADV: begin
`ifdef CP0_BADVADDR_EN
        w_idx  = CP0_BADVADDR;
        w_din  = r_badv;
        w_wr   = 1'b1;
        w_next = S_REDIR;
`else
        w_next = S_IDLE;
`endif
      end
      S_REDIR: begin
        w_pcload = 1'b1;
        w_newpc  = EXC_VECTOR;
        w_next   = S_IDLE;
      end
      S_E_SR: begin
        w_idx  = CP0_SR;
        w_din  = CP0Rdata & ~EXL_MASK;
        w_wr   = 1'b1;
        w_next = S_E_REDIR;
      end
      S_E_REDIR: begin
        w_pcload = 1'b1;
        w_newpc  = CP0Epc;
        w_next   = S_IDLE;
      end
    endcase
  end

  // Reset forces the pass-through path quiet too.
  assign CP0Idx   = Reset_n ? w_idx    : '0;
  assign CP0Din   = Reset_n ? w_din    : '0;
  assign CP0Wr    = Reset_n & w_wr;
  assign CP0Exc   = Reset_n & w_cexc;
  assign CP0Cause = Reset_n ? w_cause  : '0;
  assign MfcData  = Reset_n ? CP0Rdata : '0;
  assign Busy     = Reset_n & ~w_idle;
  assign PcLoad   = Reset_n & w_pcload;
  assign NewPC    = Reset_n ? w_newpc  : '0;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl.
// Define CP0_BADVADDR_EN to cover the BadVAddr step.
module tb_cp0_exc_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [5:0]  IntReq;
  logic        ExcAdEL, ExcRI, ExcOv, ExcSys, ExcAdES;
  logic [31:0] ExcPC, ExcBadAddr;
  logic        EretReq, MtcReq;
  logic [4:0]  MtcIdx, MfcIdx;
  logic [31:0] MtcData, CP0Rdata, CP0Epc;
  logic [4:0]  CP0Idx, CP0Cause;
  logic [31:0] CP0Din, MfcData, NewPC;
  logic        CP0Wr, CP0Exc, Busy, PcLoad;

  int nvec = 0;
  int nerr = 0;

  cp0_exc_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .IntReq(IntReq),
    .ExcAdEL(ExcAdEL), .ExcRI(ExcRI), .ExcOv(ExcOv),
    .ExcSys(ExcSys), .ExcAdES(ExcAdES),
    .ExcPC(ExcPC), .ExcBadAddr(ExcBadAddr),
    .EretReq(EretReq), .MtcReq(MtcReq),
    .MtcIdx(MtcIdx), .MtcData(MtcData), .MfcIdx(MfcIdx),
    .CP0Rdata(CP0Rdata), .CP0Epc(CP0Epc),
    .CP0Idx(CP0Idx), .CP0Din(CP0Din), .CP0Wr(CP0Wr),
    .CP0Exc(CP0Exc), .CP0Cause(CP0Cause),
    .MfcData(MfcData), .Busy(Busy),
    .PcLoad(PcLoad), .NewPC(NewPC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    IntReq = '0; ExcAdEL = 0; ExcRI = 0; ExcOv = 0;
    ExcSys = 0; ExcAdES = 0; ExcPC = '0;
    ExcBadAddr = '0; EretReq = 0; MfcIdx = '0;
    CP0Rdata = 32'hAAAA_5555; CP0Epc = '0;
    Reset_n = 0; MtcReq = 1; MtcIdx = 5'd12;
    MtcData = 32'hFFFF_FFFF; ExcOv = 1;
    #12;
    chk("rst_wr", {31'd0, CP0Wr}, 32'd0);
    chk("rst_idx", {27'd0, CP0Idx}, 32'd0);
    chk("rst_din", CP0Din, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_pcl", {31'd0, PcLoad}, 32'd0);
    chk("rst_mfc", MfcData, 32'd0);
    chk("rst_exc", {31'd0, CP0Exc}, 32'd0);
    MtcReq = 0; ExcOv = 0; MtcData = '0;
    @(negedge Clk) Reset_n = 1;
    step;

    // MTC0 SR pass-through
    MtcReq = 1; MtcIdx = 5'd12; MtcData = 32'h0000_FC01;
    #1;
    chk("mtc_wr", {31'd0, CP0Wr}, 32'd1);
    chk("mtc_idx", {27'd0, CP0Idx}, 32'd12);
    chk("mtc_din", CP0Din, 32'h0000_FC01);
    chk("mtc_busy", {31'd0, Busy}, 32'd0);
    step;
    MtcReq = 0; MfcIdx = 5'd15; CP0Rdata = 32'h0001_8000;
    #1;
    chk("mfc_idx", {27'd0, CP0Idx}, 32'd15);
    chk("mfc_data", MfcData, 32'h0001_8000);
    chk("mfc_wr", {31'd0, CP0Wr}, 32'd0);

    // Overflow exception
    ExcOv = 1; ExcPC = 32'h0000_1234;
    #1;
    chk("ov_idle_busy", {31'd0, Busy}, 32'd0);
    step;
    ExcOv = 0;
    chk("ov_epc_idx", {27'd0, CP0Idx}, 32'd14);
    chk("ov_epc_din", CP0Din, 32'h0000_1234);
    chk("ov_epc_wr", {31'd0, CP0Wr}, 32'd1);
    chk("ov_epc_exc", {31'd0, CP0Exc}, 32'd1);
    chk("ov_cause", {27'd0, CP0Cause}, 32'd12);
    chk("ov_busy", {31'd0, Busy}, 32'd1);
    CP0Rdata = 32'h0000_FC01;
    step;
    chk("ov_sr_idx", {27'd0, CP0Idx}, 32'd12);
    chk("ov_sr_din", CP0Din, 32'h0000_FC03);
    chk("ov_sr_wr", {31'd0, CP0Wr}, 32'd1);
    chk("ov_sr_exc", {31'd0, CP0Exc}, 32'd0);
    step;
    chk("ov_pcl", {31'd0, PcLoad}, 32'd1);
    chk("ov_newpc", NewPC, 32'h0000_0180);
    chk("ov_redir_wr", {31'd0, CP0Wr}, 32'd0);
    step;
    chk("ov_done_pcl", {31'd0, PcLoad}, 32'd0);
    chk("ov_done_busy", {31'd0, Busy}, 32'd0);

    // Interrupt masked by EXL (shadow 0xFC03)
    IntReq = 6'd1;
    step;
    chk("int_exl_busy", {31'd0, Busy}, 32'd0);
    IntReq = '0;

    // SR = 0x401 then interrupt taken
    MtcReq = 1; MtcIdx = 5'd12; MtcData = 32'h0000_0401;
    step;
    MtcReq = 0; ExcPC = 32'h0000_5000; IntReq = 6'd1;
    step;
    IntReq = '0;
    chk("int_busy", {31'd0, Busy}, 32'd1);
    chk("int_exc", {31'd0, CP0Exc}, 32'd1);
    chk("int_idx", {27'd0, CP0Idx}, 32'd14);
    chk("int_cause", {27'd0, CP0Cause}, 32'd0);
    chk("int_din", CP0Din, 32'h0000_5000);
    CP0Rdata = 32'h0000_0401;
    step;
    chk("int_sr_din", CP0Din, 32'h0000_0403);
    step;
    chk("int_pcl", {31'd0, PcLoad}, 32'd1);
    step;
    IntReq = 6'd1;
    step;
    chk("int_exl2_busy", {31'd0, Busy}, 32'd0);
    IntReq = '0;

    // AdEL + Sys + MTC0 together
    ExcAdEL = 1; ExcSys = 1; MtcReq = 1;
    MtcIdx = 5'd12; MtcData = 32'hFFFF_FFFF;
    ExcPC = 32'h0000_6000; ExcBadAddr = 32'hDEAD_0003;
    #1;
    chk("adel_mtc_wr", {31'd0, CP0Wr}, 32'd0);
    step;
    ExcAdEL = 0; ExcSys = 0; MtcReq = 0;
    chk("adel_cause", {27'd0, CP0Cause}, 32'd4);
    chk("adel_din", CP0Din, 32'h0000_6000);
    CP0Rdata = 32'h0000_0401;
    step;
    chk("adel_sr_din", CP0Din, 32'h0000_0403);
    step;
`ifdef CP0_BADVADDR_EN
    chk("badv_idx", {27'd0, CP0Idx}, 32'd8);
    chk("badv_din", CP0Din, 32'hDEAD_0003);
    chk("badv_wr", {31'd0, CP0Wr}, 32'd1);
    chk("badv_pcl", {31'd0, PcLoad}, 32'd0);
    step;
`endif
    chk("adel_pcl", {31'd0, PcLoad}, 32'd1);
    chk("adel_newpc", NewPC, 32'h0000_0180);
    step;
    chk("adel_done", {31'd0, Busy}, 32'd0);

    // ERET
    CP0Rdata = 32'h0000_0003; CP0Epc = 32'h0000_2000;
    EretReq = 1;
    step;
    EretReq = 0;
    chk("eret_idx", {27'd0, CP0Idx}, 32'd12);
    chk("eret_din", CP0Din, 32'h0000_0001);
    chk("eret_wr", {31'd0, CP0Wr}, 32'd1);
    chk("eret_busy", {31'd0, Busy}, 32'd1);
    chk("eret_pcl0", {31'd0, PcLoad}, 32'd0);
    step;
    chk("eret_pcl", {31'd0, PcLoad}, 32'd1);
    chk("eret_newpc", NewPC, 32'h0000_2000);
    chk("eret_wr2", {31'd0, CP0Wr}, 32'd0);
    step;
    chk("eret_done", {31'd0, Busy}, 32'd0);

    // Exception beats ERET, then reset in W_SR
    ExcRI = 1; EretReq = 1; ExcPC = 32'h0000_7000;
    step;
    ExcRI = 0; EretReq = 0;
    chk("ri_cause", {27'd0, CP0Cause}, 32'd10);
    chk("ri_idx", {27'd0, CP0Idx}, 32'd14);
    step;
    chk("ri_sr_wr", {31'd0, CP0Wr}, 32'd1);
    Reset_n = 0;
    #1;
    chk("mid_rst_wr", {31'd0, CP0Wr}, 32'd0);
    chk("mid_rst_idx", {27'd0, CP0Idx}, 32'd0);
    chk("mid_rst_din", CP0Din, 32'd0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    step;
    Reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("post_rst_pcl", {31'd0, PcLoad}, 32'd0);
      chk("post_rst_busy", {31'd0, Busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
